// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between the video pipeline stages.
// Fields: vcount/hcount[10:0], vsync/hsync, vblnk/hblnk, rgb[11:0].
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, hcount,
    input vsync, hsync,
    input vblnk, hblnk,
    input rgb
  );

  modport out (
    output vcount, hcount,
    output vsync, hsync,
    output vblnk, hblnk,
    output rgb
  );
endinterface

// File: rtl/draw_ball.sv
// Ball overlay stage: draws a square ball over the background stream and
// runs the ball motion FSM (per-frame move, bar bounce, left/right miss).
// Ports: clk65MHz, rst (async high), game_en, serve, in_if (vga_if.in),
//   out_if (vga_if.out, 1-cycle latency), ball_x/ball_y[10:0],
//   miss_left/miss_right (1-cycle registered pulses).
module draw_ball #(
  parameter int          BALL_SIZE    = 12,
  parameter int          X_INIT       = 506,
  parameter int          Y_INIT       = 378,
  parameter int          TOP_LIMIT    = 51,
  parameter int          BOTTOM_LIMIT = 717,
  parameter int          LEFT_LIMIT   = 0,
  parameter int          RIGHT_LIMIT  = 1023,
  parameter int          SPEED        = 4,
  parameter logic [11:0] BALL_COLOR   = 12'hfff
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        game_en,
  input  logic        serve,
  vga_if.in           in_if,
  vga_if.out          out_if,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        miss_left,
  output logic        miss_right
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SERVE,
    MOVE,
    MISS
  } state_t;

  localparam logic [11:0] BS  = 12'(BALL_SIZE);
  localparam logic [11:0] SP  = 12'(SPEED);
  localparam logic [11:0] TOP = 12'(TOP_LIMIT);
  localparam logic [11:0] BOT = 12'(BOTTOM_LIMIT);
  localparam logic [11:0] LFT = 12'(LEFT_LIMIT);
  localparam logic [11:0] RGT = 12'(RIGHT_LIMIT);
  localparam logic [10:0] XI  = 11'(X_INIT);
  localparam logic [10:0] YI  = 11'(Y_INIT);

  state_t state;
  logic   dir_x;   // 1 = moving right
  logic   dir_y;   // 1 = moving down
  logic   vblnk_prev;
  logic   tick;

  logic [11:0] x12, y12, hc12, vc12;
  logic        in_ball;
  logic        hit_l, hit_r, hit_t, hit_b;
  logic [10:0] nx, ny;

  assign tick = in_if.vblnk & ~vblnk_prev;

  // All geometry is done one bit wider so sums never wrap.
  assign x12  = {1'b0, ball_x};
  assign y12  = {1'b0, ball_y};
  assign hc12 = {1'b0, in_if.hcount};
  assign vc12 = {1'b0, in_if.vcount};

  assign in_ball = (state != IDLE)
                 & ~in_if.vblnk & ~in_if.hblnk
                 & (hc12 >= x12) & (hc12 < x12 + BS)
                 & (vc12 >= y12) & (vc12 < y12 + BS);

  assign hit_l = ~dir_x & (x12 < LFT + SP);
  assign hit_r =  dir_x & (x12 + BS + SP > RGT + 12'd1);
  assign hit_t = ~dir_y & (y12 < TOP + SP);
  assign hit_b =  dir_y & (y12 + BS + SP > BOT + 12'd1);

  // The plain step may underflow when a hit is pending; the clamp wins.
  always_comb begin
    nx = 11'(dir_x ? x12 + SP : x12 - SP);
    ny = 11'(dir_y ? y12 + SP : y12 - SP);
    if (hit_l)      nx = 11'(LFT);
    else if (hit_r) nx = 11'(RGT + 12'd1 - BS);
    if (hit_t)      ny = 11'(TOP);
    else if (hit_b) ny = 11'(BOT + 12'd1 - BS);
  end

  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ball_x     <= XI;
      ball_y     <= YI;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      vblnk_prev <= 1'b0;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
    end else begin
      vblnk_prev <= in_if.vblnk;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      if (!game_en) begin
        state  <= IDLE;
        ball_x <= XI;
        ball_y <= YI;
        dir_x  <= 1'b1;
        dir_y  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: state <= WAIT_SERVE;
          WAIT_SERVE: if (serve) state <= MOVE;
          MOVE: if (tick) begin
            ball_x <= nx;
            ball_y <= ny;
            if (hit_t)      dir_y <= 1'b1;
            else if (hit_b) dir_y <= 1'b0;
            if (hit_l | hit_r) begin
              state      <= MISS;
              miss_left  <= hit_l;
              miss_right <= hit_r;
            end
          end
          // dir_x still points at the side that missed; serve away from it.
          MISS: if (tick) begin
            state  <= WAIT_SERVE;
            ball_x <= XI;
            ball_y <= YI;
            dir_x  <= ~dir_x;
            dir_y  <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      out_if.vcount <= '0;
      out_if.hcount <= '0;
      out_if.vsync  <= 1'b0;
      out_if.hsync  <= 1'b0;
      out_if.vblnk  <= 1'b0;
      out_if.hblnk  <= 1'b0;
      out_if.rgb    <= '0;
    end else begin
      out_if.vcount <= in_if.vcount;
      out_if.hcount <= in_if.hcount;
      out_if.vsync  <= in_if.vsync;
      out_if.hsync  <= in_if.hsync;
      out_if.vblnk  <= in_if.vblnk;
      out_if.hblnk  <= in_if.hblnk;
      out_if.rgb    <= in_ball ? BALL_COLOR : in_if.rgb;
    end
  end

endmodule
